// File: rtl/stream_eot_fifo.sv
// FWFT stream FIFO carrying an eot bit per word; registered head slot and flags.
// Ports: if_din/eot/write/full_n in, if_dout/eot/read/empty_n out; STREAM_FIFO_OCCUPANCY_EN adds if_occupancy.
module stream_eot_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_din_eot,
  output logic                  if_full_n,
  input  logic                  if_write,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_dout_eot,
  output logic                  if_empty_n,
  input  logic                  if_read
`ifdef STREAM_FIFO_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH):0] if_occupancy
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int W      = DATA_WIDTH + 1;

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  localparam ptr_t LAST = ptr_t'(DEPTH - 1);
  localparam cnt_t FULL = cnt_t'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  ptr_t         wr_ptr, rd_ptr;
  ptr_t         wr_nxt, rd_nxt;
  cnt_t         count, count_nxt;
  logic [W-1:0] head_q, head_nxt;
  logic         full_n_q, empty_n_q;
  logic         do_wr, do_rd;

  assign do_wr = if_write && full_n_q;
  assign do_rd = if_read && empty_n_q;

  always_comb begin
    wr_nxt    = wr_ptr;
    rd_nxt    = rd_ptr;
    count_nxt = count;
    head_nxt  = head_q;
    if (do_wr)
      wr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
    if (do_rd)
      rd_nxt = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    // The incoming word becomes head only when nothing older remains.
    if (count_nxt != '0) begin
      if (do_wr && (wr_ptr == rd_nxt))
        head_nxt = {if_din_eot, if_din};
      else
        head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (do_wr)
      mem[wr_ptr] <= {if_din_eot, if_din};
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_q    <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      count     <= count_nxt;
      head_q    <= head_nxt;
      full_n_q  <= (count_nxt != FULL);
      empty_n_q <= (count_nxt != '0);
    end
  end

  assign if_full_n   = full_n_q;
  assign if_empty_n  = empty_n_q;
  assign if_dout     = head_q[DATA_WIDTH-1:0];
  assign if_dout_eot = head_q[DATA_WIDTH];

`ifdef STREAM_FIFO_OCCUPANCY_EN
  assign if_occupancy = count;
`endif

endmodule
